// File: rtl/mul_accum_pkg.sv
// rtl/mul_accum_pkg.sv - shared widths, credit depth and result type for mul_accum
package mul_accum_pkg;

    localparam int DEF_PROD_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 16;
    localparam int DEF_BURST_LEN   = 4;
    localparam int DEF_MUL_LATENCY = 0;

    // Output buffer depth; also the number of bursts that may be outstanding.
    localparam int CREDIT_DEPTH = 2;

    typedef struct packed {
        logic [DEF_ACC_WIDTH-1:0] sum;
        logic                     ovf;
    } result_t;

endpackage

// File: rtl/mul_accum_fifo2.sv
// rtl/mul_accum_fifo2.sv - two-entry result FIFO with registered head
module mul_accum_fifo2
    import mul_accum_pkg::*;
#(
    parameter type T = result_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    T           slot1;
    logic [1:0] cnt;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

    // Head always holds the oldest entry; slot1 holds the second when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        head <= din;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        slot1 <= din;
                        cnt   <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= slot1;
                        if (push) begin
                            slot1 <= din;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mul_accum.sv
// rtl/mul_accum.sv - burst accumulator behind a fixed-latency multiplier
module mul_accum
    import mul_accum_pkg::*;
#(
    parameter int PROD_WIDTH  = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  sum_ovf,
    output logic                  sum_valid,
    input  logic                  sum_ready
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CW    = $clog2(CREDIT_DEPTH + 1);
    localparam int WW    = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
    } acc_result_t;

    logic [CNT_W-1:0]     issue_cnt;
    logic [CNT_W-1:0]     arr_cnt;
    logic [CW-1:0]        credits;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_acc;
    logic                 issue;
    logic                 last_issue;
    logic                 pop;
    logic                 pv;
    logic                 first;
    logic [ACC_WIDTH-1:0] base;
    logic [WW-1:0]        wide;
    logic                 ovf_nxt;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    acc_result_t          head;

    assign in_ready   = (credits != '0);
    assign issue      = in_valid && in_ready;
    assign last_issue = issue && (issue_cnt == LAST_BEAT);
    assign pop        = sum_valid && sum_ready;

    // Issue-side beat counter and burst credits (one credit per buffer slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            credits   <= CW'(CREDIT_DEPTH);
        end else begin
            if (issue) begin
                issue_cnt <= (issue_cnt == LAST_BEAT) ? '0 : issue_cnt + CNT_W'(1);
            end
            if (last_issue && !pop) begin
                credits <= credits - CW'(1);
            end else if (pop && !last_issue) begin
                credits <= credits + CW'(1);
            end
        end
    end

    // Issue strobe follows the product through the multiplier pipeline.
    generate
        if (MUL_LATENCY == 0) begin : g_no_dly
            assign pv = issue;
        end else begin : g_dly
            logic [MUL_LATENCY-1:0] dly;
            // Shift register clears on reset so pre-reset products are ignored.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly <= '0;
                end else begin
                    dly[0] <= issue;
                    for (int i = 1; i < MUL_LATENCY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end
            assign pv = dly[MUL_LATENCY-1];
        end
    endgenerate

    assign first   = (arr_cnt == '0);
    assign base    = first ? '0 : acc;
    assign wide    = {1'b0, base} + WW'(prod);
    assign ovf_nxt = (first ? 1'b0 : ovf_acc) | wide[ACC_WIDTH];
    assign push    = pv && (arr_cnt == LAST_BEAT);

    // Running sum of the current burst; the first beat restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_cnt <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (pv) begin
            arr_cnt <= (arr_cnt == LAST_BEAT) ? '0 : arr_cnt + CNT_W'(1);
            acc     <= wide[ACC_WIDTH-1:0];
            ovf_acc <= ovf_nxt;
        end
    end

    mul_accum_fifo2 #(
        .T(acc_result_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push && (!fifo_full || pop)),
        .din   (acc_result_t'{sum: wide[ACC_WIDTH-1:0], ovf: ovf_nxt}),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sum       = head.sum;
    assign sum_ovf   = head.ovf;
    assign sum_valid = !fifo_empty;

endmodule

// File: tb/tb_mul_accum.sv
// tb/tb_mul_accum.sv - directed and randomized checks for mul_accum
module tb_mul_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Instance A: ACC 16, BURST 4, latency 2
    logic        iv_a, ir_a, sr_a, sv_a, ovf_a;
    logic [7:0]  op_a, pa1, pa2;
    logic [15:0] sum_a;
    always_ff @(posedge clk) begin
        pa1 <= op_a;
        pa2 <= pa1;
    end
    mul_accum #(.PROD_WIDTH(8), .ACC_WIDTH(16), .BURST_LEN(4), .MUL_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .prod(pa2),
        .sum(sum_a), .sum_ovf(ovf_a), .sum_valid(sv_a), .sum_ready(sr_a));

    // Instance B: ACC 9 for wraparound, BURST 4, latency 2
    logic        iv_b, ir_b, sr_b, sv_b, ovf_b;
    logic [7:0]  op_b, pb1, pb2;
    logic [8:0]  sum_b;
    always_ff @(posedge clk) begin
        pb1 <= op_b;
        pb2 <= pb1;
    end
    mul_accum #(.PROD_WIDTH(8), .ACC_WIDTH(9), .BURST_LEN(4), .MUL_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .prod(pb2),
        .sum(sum_b), .sum_ovf(ovf_b), .sum_valid(sv_b), .sum_ready(sr_b));

    // Instance C: latency 3, used for reset mid-burst
    logic        iv_c, ir_c, sr_c, sv_c, ovf_c;
    logic [7:0]  op_c, pc1, pc2, pc3;
    logic [15:0] sum_c;
    always_ff @(posedge clk) begin
        pc1 <= op_c;
        pc2 <= pc1;
        pc3 <= pc2;
    end
    mul_accum #(.PROD_WIDTH(8), .ACC_WIDTH(16), .BURST_LEN(4), .MUL_LATENCY(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .prod(pc3),
        .sum(sum_c), .sum_ovf(ovf_c), .sum_valid(sv_c), .sum_ready(sr_c));

    // Instance D: BURST 1, latency 0, randomized traffic
    logic        iv_d, ir_d, sr_d, sv_d, ovf_d;
    logic [7:0]  op_d;
    logic [15:0] sum_d;
    mul_accum #(.PROD_WIDTH(8), .ACC_WIDTH(16), .BURST_LEN(1), .MUL_LATENCY(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_d), .in_ready(ir_d), .prod(op_d),
        .sum(sum_d), .sum_ovf(ovf_d), .sum_valid(sv_d), .sum_ready(sr_d));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int         bp_ops [8] = '{1, 2, 3, 4, 10, 20, 30, 40};
    logic [7:0] q[$];
    int         m_cred;
    int         m_occ;
    logic       m_issue, m_pop;

    initial begin
        rst_n = 1'b0;
        {iv_a, sr_a, iv_b, sr_b, iv_c, sr_c, iv_d, sr_d} = '0;
        op_a = '0; op_b = '0; op_c = '0; op_d = '0;
        step();
        step();

        // Reset values
        chk("rst_sum_a", sum_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_sv_a", sv_a, 0);
        chk("rst_ir_a", ir_a, 1);
        chk("rst_ir_b", ir_b, 1);
        chk("rst_sv_d", sv_d, 0);
        chk("rst_ovf_d", ovf_d, 0);
        rst_n = 1'b1;

        // Basic sum 15+14+225+1 = 255, valid exactly at cycle 6
        sr_a = 1'b1;
        for (int i = 0; i < 9; i++) begin
            iv_a = (i < 4);
            op_a = (i == 0) ? 8'd15 : (i == 1) ? 8'd14 : (i == 2) ? 8'd225 : 8'd1;
            if (i < 4) chk("basic_ir", ir_a, 1);
            if (i == 4 || i == 5 || i == 7) chk("basic_sv_low", sv_a, 0);
            if (i == 6) begin
                chk("basic_sv", sv_a, 1);
                chk("basic_sum", sum_a, 255);
                chk("basic_ovf", ovf_a, 0);
            end
            step();
        end

        // Overflow in a 9-bit accumulator, then a clean burst
        sr_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            iv_b = (i < 8);
            op_b = (i < 4) ? 8'd225 : 8'd1;
            if (i == 6) begin
                chk("ovf_sv", sv_b, 1);
                chk("ovf_sum", sum_b, 388);
                chk("ovf_flag", ovf_b, 1);
            end
            if (i == 10) begin
                chk("ovf2_sv", sv_b, 1);
                chk("ovf2_sum", sum_b, 4);
                chk("ovf2_flag", ovf_b, 0);
            end
            step();
        end
        iv_b = 1'b0;

        // Backpressure: two sums queue, in_ready drops after the 8th beat
        sr_a = 1'b0;
        iv_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            op_a = (i < 8) ? 8'(bp_ops[i]) : 8'd0;
            if (i == 7) chk("bp_ir_beat8", ir_a, 1);
            if (i == 8) chk("bp_ir_low", ir_a, 0);
            if (i == 12 || i == 14) begin
                chk("bp_hold_sv", sv_a, 1);
                chk("bp_hold_sum", sum_a, 10);
                chk("bp_hold_ir", ir_a, 0);
            end
            step();
        end
        iv_a = 1'b0;
        sr_a = 1'b1;
        chk("bp_pop1_sum", sum_a, 10);
        step();
        chk("bp_pop2_sv", sv_a, 1);
        chk("bp_pop2_sum", sum_a, 100);
        chk("bp_ir_back", ir_a, 1);
        step();
        chk("bp_drained", sv_a, 0);

        // Simultaneous push and pop at occupancy 1
        sr_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            iv_a = (i < 8);
            op_a = (i < 4) ? 8'd1 : 8'd2;
            sr_a = (i >= 9);
            if (i == 6 || i == 9) begin
                chk("pp_first_sv", sv_a, 1);
                chk("pp_first_sum", sum_a, 4);
            end
            if (i == 10) begin
                chk("pp_second_sv", sv_a, 1);
                chk("pp_second_sum", sum_a, 8);
            end
            if (i == 11) chk("pp_empty", sv_a, 0);
            step();
        end
        iv_a = 1'b0;

        // Reset mid-burst with a buffered sum and products in flight
        sr_c = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iv_c = (i < 6);
            op_c = (i < 4) ? 8'd5 : 8'd50;
            step();
        end
        chk("rr_pre_sv", sv_c, 1);
        chk("rr_pre_sum", sum_c, 20);
        rst_n = 1'b0;
        #1;
        chk("rr_async_sv", sv_c, 0);
        chk("rr_async_sum", sum_c, 0);
        chk("rr_async_ovf", ovf_c, 0);
        chk("rr_async_ir", ir_c, 1);
        step();
        rst_n = 1'b1;
        sr_c  = 1'b1;
        for (int i = 8; i < 17; i++) begin
            iv_c = (i < 12);
            op_c = 8'd10;
            if (i == 14) chk("rr_no_stale", sv_c, 0);
            if (i == 15) begin
                chk("rr_fresh_sv", sv_c, 1);
                chk("rr_fresh_sum", sum_c, 40);
                chk("rr_fresh_ovf", ovf_c, 0);
            end
            step();
        end
        iv_c = 1'b0;

        // BURST_LEN=1 randomized traffic against a reference model
        m_cred = 2;
        m_occ  = 0;
        for (int i = 0; i < 1000; i++) begin
            iv_d = 1'($urandom_range(0, 1));
            sr_d = 1'($urandom_range(0, 1));
            op_d = 8'($urandom_range(0, 255));
            chk("rnd_ir", ir_d, (m_cred != 0));
            chk("rnd_sv", sv_d, (m_occ != 0));
            if (m_occ != 0) begin
                chk("rnd_sum", sum_d, q[0]);
                chk("rnd_ovf", ovf_d, 0);
            end
            m_issue = iv_d && ir_d;
            m_pop   = sv_d && sr_d;
            chk("rnd_no_push_full", (m_issue && !m_pop && m_occ == 2), 0);
            if (m_pop && q.size() != 0) void'(q.pop_front());
            if (m_issue) q.push_back(op_d);
            m_occ  = m_occ + int'(m_issue) - int'(m_pop);
            m_cred = m_cred - int'(m_issue) + int'(m_pop);
            step();
        end
        iv_d = 1'b0;
        sr_d = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_accum.md
Name: mul_accum

Overview:
- Downstream stage for the registered small multiplier: consumes its product stream and sums every BURST_LEN consecutive products into one wide result (dot-product style).
- Issues operands to the multiplier through an in_valid/in_ready handshake.
- Tracks each product through the multiplier's fixed pipeline latency with its own delay line.
- Presents completed sums on a valid/ready output with a 2-entry buffer, so output backpressure never drops products already inside the multiplier.

Parameters:
- PROD_WIDTH, 8, product width (2x operand width of the multiplier).
- ACC_WIDTH, 16, accumulator/sum width; must be >= PROD_WIDTH.
- BURST_LEN, 4, products per sum; must be >= 1.
- MUL_LATENCY, 0, total register stages between operand issue and product at prod; 0 means prod is combinational from same-cycle operands.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  operand pair presented to the multiplier this cycle.
- in_ready  out  1  block can accept an issue; a beat is issued when in_valid && in_ready.
- prod  in  PROD_WIDTH  multiplier output, valid MUL_LATENCY cycles after issue.
- sum  out  ACC_WIDTH  completed burst sum (head of output buffer).
- sum_ovf  out  1  sum wrapped modulo 2^ACC_WIDTH during its burst.
- sum_valid  out  1  sum/sum_ovf hold a result.
- sum_ready  in  1  consumer accepts; pop on sum_valid && sum_ready.

Behaviour:
- Reset (async assert, sync release): sum=0, sum_ovf=0, sum_valid=0, in_ready=1. Issue count, arrival count, delay line, accumulator and buffer are all cleared; credits=2.
- Issue side:
  - issue_cnt counts issued beats modulo BURST_LEN.
  - An issue with issue_cnt==BURST_LEN-1 is a last-beat issue and decrements credits.
  - A sum pop increments credits. A last-beat issue and a pop in the same cycle leave credits unchanged.
  - in_ready = (credits != 0); purely registered-state driven, with no combinational path from in_valid or sum_ready.
- Delay line: an MUL_LATENCY-deep shift register carries the issue strobe. pv = delayed strobe (pv = issue strobe when MUL_LATENCY=0).
- Accumulate (on pv):
  - arr_cnt counts arrivals modulo BURST_LEN.
  - nxt = (arr_cnt==0 ? 0 : acc) + zero-extended prod, taken modulo 2^ACC_WIDTH.
  - ovf_acc = (arr_cnt==0 ? 0 : ovf_acc) | carry-out.
  - On arr_cnt==BURST_LEN-1, push {nxt, ovf} into the buffer; acc is not needed afterwards.
  - Unsigned arithmetic only.
- Latency: last beat issued at cycle t -> product at t+MUL_LATENCY -> sum_valid=1 at t+MUL_LATENCY+1 (buffer was empty).
- Output buffer: 2-entry FIFO, registered outputs, FIFO order.
  - Simultaneous push and pop is legal at any occupancy 0..2.
  - Push when full is impossible because of credits; the bench asserts this.
- While sum_valid=1 and sum_ready=0, sum/sum_ovf are held stable.
- BURST_LEN=1: every product becomes a sum; ovf is always 0 when ACC_WIDTH > PROD_WIDTH.
- Reset mid-operation:
  - Partial burst and in-flight strobes are discarded.
  - Products arriving after reset release from pre-reset issues are ignored, because the delay line was cleared.
  - Buffered sums are lost.
- in_valid while in_ready=0: no issue and no state change. The upstream must hold the operands.

Decomposition:
- Package mul_accum_pkg: default widths, the credit depth constant (2), and a result struct type {sum, ovf}.
- One sub-module: mul_accum_fifo2, the 2-entry FIFO of the result struct with push/pop/full/empty and registered head.
- The delay line and counters stay inline.

Test Plan:
- Basic sum, MUL_LATENCY=2, BURST_LEN=4: issue products 15,14,225,1 back-to-back at cycles 0..3 with sum_ready=1 -> sum=255, sum_ovf=0, sum_valid high exactly at cycle 6 for one cycle.
- Overflow, ACC_WIDTH=9: four products of 225 -> sum=388 (900-512), sum_ovf=1. The next burst of 1,1,1,1 gives sum=4, sum_ovf=0, so the ovf flag does not carry into later bursts.
- Backpressure: sum_ready=0, continuous in_valid.
  - in_ready falls the cycle after the 2nd last-beat issue (beat 8).
  - Two sums (values distinct) are queued and held stable.
  - Raising sum_ready pops them in order; in_ready returns the cycle after the first pop.
- Simultaneous push/pop: occupancy 1 with sum_ready=1 when a new sum completes -> occupancy stays 1, no loss or duplicate, values in order.
- Reset mid-burst, MUL_LATENCY=3: issue 2 beats, pulse rst_n low for 1 cycle while products are in flight.
  - All outputs go to their reset values immediately.
  - A fresh burst of 4 products of 10 -> sum=40 (stale products not included).
- BURST_LEN=1, MUL_LATENCY=0: random in_valid and random sum_ready for 1000 cycles -> the stream of sums equals the stream of products, in_ready never causes a push into a full buffer, and the in_ready/sum_valid reference model matches.
